f_nextpc: RTL and testbench
===========================

Name: f_nextpc

Overview:
- Fetch-stage next-PC generator for the dual-issue RV32I core. Each cycle it supplies the word-address pair pc1/pc2 to instruction memory.
- It predicts the following fetch PC using a small direct-mapped BTB with 2-bit counters. The prediction travels down the pipe with the pair, and the decode PC check compares it against the computed target.
- It accepts redirects from decode (jal mispredict) and execute (branch/jalr mispredict), and trains the BTB from resolved control-flow updates.

Parameters:
- BTB_IDX, 4, log2 of BTB entries (16 entries); index = pc[BTB_IDX-1:0], tag = pc[12:BTB_IDX]
- PC_W, 13, word-address PC width (8K-word instruction space)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold fetch PC (downstream back-pressure)
- d_fail  in  1  decode-stage jal mispredict (fail_predict)
- d_true_pc  in  13  decode-computed correct target
- e_fail  in  1  execute-stage branch/jalr mispredict
- e_true_pc  in  13  execute-computed correct next PC
- upd_valid  in  1  resolved control-flow instruction update
- upd_pc  in  13  PC of resolved instruction
- upd_target  in  13  resolved taken target
- upd_taken  in  1  resolved direction
- upd_jal  in  1  resolved instruction is jal (always taken)
- pc1  out  13  fetch PC, slot 0 (= pc register)
- pc2  out  13  pc1+1 mod 8192, slot 1
- pc_predicted  out  13  predicted next fetch PC for this pair (combinational)
- pred_slot  out  1  0: slot 0 predicted taken; 1: slot 1 predicted taken
- pred_taken  out  1  either slot predicted taken

Behaviour:
- Reset: pc register = 0, so pc1=0 and pc2=1. All BTB valid bits and counters are cleared. pred_taken=0, pred_slot=0, pc_predicted=2.
- Reset asserted mid-operation overrides all redirects, updates and stall in that cycle.
- Lookup is combinational on pc1 and pc2, each against its own index/tag.
  - Hit = valid && tag match.
  - Taken = hit && ctr[1].
- Prediction order:
  - Slot 0 taken: pc_predicted = target0, pred_slot=0, pred_taken=1.
  - Else slot 1 taken: pc_predicted = target1, pred_slot=1, pred_taken=1.
  - Else pc_predicted = pc1+2 mod 8192, pred_slot=0, pred_taken=0.
- Next pc register value, in priority order:
  1. rst → 0
  2. e_fail → e_true_pc
  3. d_fail → d_true_pc
  4. stall → hold
  5. otherwise → pc_predicted
- Redirects take effect in the next cycle: 1-cycle latency from the fail input to the new pc1.
- A redirect overrides stall. The downstream flush is not this block's job.
- All PC arithmetic is 13-bit and wraps modulo 8192; there is no overflow flag.
- BTB update, applied on the rising edge when upd_valid=1, at index = upd_pc[3:0]:
  - Entry hit (valid and tag equal), upd_jal=1: ctr = 3; target = upd_target.
  - Entry hit, branch taken: ctr = sat_inc(ctr); target = upd_target.
  - Entry hit, branch not-taken: ctr = sat_dec(ctr); target unchanged.
  - Entry miss, taken or jal: allocate (valid=1, tag, target); ctr = 3 if jal, else 2.
  - Entry miss, not-taken: no allocation.
- Counters saturate at 0 and 3; there is no wrap.
- Update and lookup on the same index in the same cycle: lookup returns the pre-update contents (read-before-write).
- Updates proceed regardless of stall and redirects.
- The BTB is flop-based, with no SRAM read latency.

Decomposition:
- Shared package / define.vh additions:
  - PC_W and BTB_IDX defaults
  - counter encodings: SNT=0, WNT=1, WT=2, ST=3
  - the PC reset vector (0)
- One natural sub-module: f_btb.
  - Holds the 16-entry storage.
  - Provides two combinational read ports (hit, taken, target), one write port, and the counter update logic.
- f_nextpc itself is the pc register, the prediction mux and the redirect priority.

Test Plan:
- Reset, then run free with an empty BTB → pc1 sequence 0,2,4,6; pc2 = pc1+1; pc_predicted = pc1+2; pred_taken=0.
- Wrap: redirect to 8191 → pc1=8191, pc2=0, pc_predicted=1; next cycle pc1=1.
- Train and hit:
  - upd jal at pc=0x10, target=0x40.
  - Redirect to 0x10 → pc_predicted=0x40, pred_slot=0, pred_taken=1; next pc1=0x40.
  - Same entry reached via slot 1: pc1=0x0F → pred_slot=1, pc_predicted=0x40.
- Counter training:
  - Branch at 0x20 taken → allocated at ctr=2 (predict taken).
  - Two not-taken updates → ctr=0, falls through to pc1+2.
  - Three taken updates → ctr saturates at 3.
- Priority: in one cycle assert stall, d_fail (d_true_pc=0x100) and e_fail (e_true_pc=0x200) → next pc1=0x200. With d_fail+stall only → 0x100. With stall only → pc1 held over 3 cycles.
- Simultaneous update to the index under lookup → that cycle's prediction uses old contents; the next cycle's uses new. rst asserted together with e_fail → pc1=0 and BTB cleared.

Source files
------------

// File: rtl/f_nextpc_pkg.sv
// rtl/f_nextpc_pkg.sv - shared widths, counter encodings and reset vector for the fetch next-PC block
package f_nextpc_pkg;

  localparam int PC_W_DEF    = 13;
  localparam int BTB_IDX_DEF = 4;

  // Word-address reset vector.
  localparam int PC_RESET_VEC = 0;

  // 2-bit branch direction counter: upper bit set means predict taken.
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  function automatic ctr_t sat_inc(input ctr_t c);
    case (c)
      SNT:     sat_inc = WNT;
      WNT:     sat_inc = WT;
      default: sat_inc = ST;
    endcase
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    case (c)
      ST:      sat_dec = WT;
      WT:      sat_dec = WNT;
      default: sat_dec = SNT;
    endcase
  endfunction

endpackage

// File: rtl/f_btb.sv
// rtl/f_btb.sv - flop-based direct-mapped BTB with two read ports and one training port
module f_btb
  import f_nextpc_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int BTB_IDX = BTB_IDX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] rd0_pc,
  output logic            rd0_taken,
  output logic [PC_W-1:0] rd0_target,
  input  logic [PC_W-1:0] rd1_pc,
  output logic            rd1_taken,
  output logic [PC_W-1:0] rd1_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            upd_jal
);

  localparam int ENTRIES = 1 << BTB_IDX;
  localparam int TAG_W   = PC_W - BTB_IDX;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [PC_W-1:0]   target_q [ENTRIES];
  ctr_t              ctr_q    [ENTRIES];

  logic [BTB_IDX-1:0] rd0_idx, rd1_idx, upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               upd_hit, upd_redirects;
  ctr_t               ctr_nxt;

  assign rd0_idx = rd0_pc[BTB_IDX-1:0];
  assign rd1_idx = rd1_pc[BTB_IDX-1:0];
  assign upd_idx = upd_pc[BTB_IDX-1:0];
  assign upd_tag = upd_pc[PC_W-1:BTB_IDX];

  // Reads see the registered contents, so a same-cycle write is not visible until the next cycle.
  assign rd0_taken  = valid_q[rd0_idx] && (tag_q[rd0_idx] == rd0_pc[PC_W-1:BTB_IDX])
                      && ctr_q[rd0_idx][1];
  assign rd0_target = target_q[rd0_idx];
  assign rd1_taken  = valid_q[rd1_idx] && (tag_q[rd1_idx] == rd1_pc[PC_W-1:BTB_IDX])
                      && ctr_q[rd1_idx][1];
  assign rd1_target = target_q[rd1_idx];

  assign upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_redirects = upd_jal || upd_taken;

  // Counter training for an entry that already holds this instruction.
  always_comb begin
    ctr_nxt = ctr_q[upd_idx];
    if (upd_jal)        ctr_nxt = ST;
    else if (upd_taken) ctr_nxt = sat_inc(ctr_q[upd_idx]);
    else                ctr_nxt = sat_dec(ctr_q[upd_idx]);
  end

  // Valid bits and counters: cleared on reset, trained or allocated on updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= SNT;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_nxt;
      end else if (upd_redirects) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= upd_jal ? ST : WT;
      end
    end
  end

  // Tags and targets need no reset; a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_redirects) begin
      target_q[upd_idx] <= upd_target;
      if (!upd_hit) tag_q[upd_idx] <= upd_tag;
    end
  end

endmodule

// File: rtl/f_nextpc.sv
// rtl/f_nextpc.sv - fetch PC register, BTB-based prediction mux and redirect priority
module f_nextpc
  import f_nextpc_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int BTB_IDX = BTB_IDX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            d_fail,
  input  logic [PC_W-1:0] d_true_pc,
  input  logic            e_fail,
  input  logic [PC_W-1:0] e_true_pc,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            upd_jal,
  output logic [PC_W-1:0] pc1,
  output logic [PC_W-1:0] pc2,
  output logic [PC_W-1:0] pc_predicted,
  output logic            pred_slot,
  output logic            pred_taken
);

  localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);
  localparam logic [PC_W-1:0] PC_TWO   = PC_W'(2);
  localparam logic [PC_W-1:0] PC_RESET = PC_W'(PC_RESET_VEC);

  logic [PC_W-1:0] pc_q, pc_next;
  logic            s0_taken, s1_taken;
  logic [PC_W-1:0] s0_target, s1_target;

  assign pc1 = pc_q;
  assign pc2 = pc_q + PC_ONE;

  f_btb #(
    .PC_W    (PC_W),
    .BTB_IDX (BTB_IDX)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .rd0_pc     (pc1),
    .rd0_taken  (s0_taken),
    .rd0_target (s0_target),
    .rd1_pc     (pc2),
    .rd1_taken  (s1_taken),
    .rd1_target (s1_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .upd_jal    (upd_jal)
  );

  // Earlier slot wins; with no taken slot the pair falls through to pc1+2.
  always_comb begin
    pc_predicted = pc_q + PC_TWO;
    pred_slot    = 1'b0;
    pred_taken   = 1'b0;
    if (s0_taken) begin
      pc_predicted = s0_target;
      pred_taken   = 1'b1;
    end else if (s1_taken) begin
      pc_predicted = s1_target;
      pred_slot    = 1'b1;
      pred_taken   = 1'b1;
    end
  end

  // Redirects outrank stall; the older (execute) redirect outranks decode.
  always_comb begin
    pc_next = pc_predicted;
    if (e_fail)      pc_next = e_true_pc;
    else if (d_fail) pc_next = d_true_pc;
    else if (stall)  pc_next = pc_q;
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= PC_RESET;
    else     pc_q <= pc_next;
  end

endmodule

// File: tb/tb_f_nextpc.sv
// tb/tb_f_nextpc.sv - directed and randomized self-checking bench for f_nextpc
module tb_f_nextpc;

  logic        clk = 1'b0;
  logic        rst, stall, d_fail, e_fail, upd_valid, upd_taken, upd_jal;
  logic [12:0] d_true_pc, e_true_pc, upd_pc, upd_target;
  logic [12:0] pc1, pc2, pc_predicted;
  logic        pred_slot, pred_taken;

  int errors = 0;
  int checks = 0;

  int m_pc;
  int m_valid [16];
  int m_tag   [16];
  int m_tgt   [16];
  int m_ctr   [16];

  always #5 clk = ~clk;

  f_nextpc dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .d_fail       (d_fail),
    .d_true_pc    (d_true_pc),
    .e_fail       (e_fail),
    .e_true_pc    (e_true_pc),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .upd_jal      (upd_jal),
    .pc1          (pc1),
    .pc2          (pc2),
    .pc_predicted (pc_predicted),
    .pred_slot    (pred_slot),
    .pred_taken   (pred_taken)
  );

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_is_taken(input int pc);
    int i;
    i = pc % 16;
    return (m_valid[i] != 0) && (m_tag[i] == pc / 16) && (m_ctr[i] >= 2);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
      m_ctr[i]   = 0;
    end
  endtask

  task automatic m_update(input int pc, input int tgt, input bit tk, input bit jal);
    int i;
    i = pc % 16;
    if (m_valid[i] != 0 && m_tag[i] == pc / 16) begin
      if (jal) begin
        m_ctr[i] = 3;
        m_tgt[i] = tgt;
      end else if (tk) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (tk || jal) begin
      m_valid[i] = 1;
      m_tag[i]   = pc / 16;
      m_tgt[i]   = tgt;
      m_ctr[i]   = jal ? 3 : 2;
    end
  endtask

  // One clock: check outputs at the falling edge against the model, then advance the model.
  task automatic step();
    int pp, slot, tk, p2;
    @(negedge clk);
    p2 = (m_pc + 1) % 8192;
    if (m_is_taken(m_pc)) begin
      pp = m_tgt[m_pc % 16]; slot = 0; tk = 1;
    end else if (m_is_taken(p2)) begin
      pp = m_tgt[p2 % 16]; slot = 1; tk = 1;
    end else begin
      pp = (m_pc + 2) % 8192; slot = 0; tk = 0;
    end
    chk("pc1", pc1, 13'(m_pc));
    chk("pc2", pc2, 13'(p2));
    chk("pc_predicted", pc_predicted, 13'(pp));
    chk("pred_slot", {12'b0, pred_slot}, 13'(slot));
    chk("pred_taken", {12'b0, pred_taken}, 13'(tk));
    if (rst) begin
      m_pc = 0;
      m_clear();
    end else begin
      if (upd_valid) m_update(int'(upd_pc), int'(upd_target), upd_taken, upd_jal);
      if (e_fail)      m_pc = int'(e_true_pc);
      else if (d_fail) m_pc = int'(d_true_pc);
      else if (!stall) m_pc = pp;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0; d_fail = 1'b0; e_fail = 1'b0; upd_valid = 1'b0;
    upd_taken = 1'b0; upd_jal = 1'b0;
    d_true_pc = '0; e_true_pc = '0; upd_pc = '0; upd_target = '0;
  endtask

  task automatic redirect(input logic [12:0] pc);
    idle();
    e_fail = 1'b1;
    e_true_pc = pc;
    step();
    idle();
  endtask

  task automatic train(input logic [12:0] pc, input logic [12:0] tgt, input logic tk, input logic jal);
    idle();
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_jal = jal;
    step();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_pc = 0;
    m_clear();

    step();
    chk("reset_pc1", pc1, 13'd0);
    chk("reset_pc2", pc2, 13'd1);
    chk("reset_pred", pc_predicted, 13'd2);
    chk("reset_taken", {12'b0, pred_taken}, 13'd0);

    idle();
    for (int i = 0; i < 4; i++) begin
      chk("free_pc1", pc1, 13'(2 * i));
      step();
    end

    redirect(13'd8191);
    chk("wrap_pc1", pc1, 13'd8191);
    chk("wrap_pc2", pc2, 13'd0);
    chk("wrap_pred", pc_predicted, 13'd1);
    step();
    chk("wrap_next", pc1, 13'd1);

    train(13'h10, 13'h40, 1'b0, 1'b1);
    redirect(13'h10);
    chk("jal_pred", pc_predicted, 13'h40);
    chk("jal_slot", {12'b0, pred_slot}, 13'd0);
    chk("jal_taken", {12'b0, pred_taken}, 13'd1);
    step();
    chk("jal_follow", pc1, 13'h40);
    redirect(13'h0F);
    chk("slot1_slot", {12'b0, pred_slot}, 13'd1);
    chk("slot1_pred", pc_predicted, 13'h40);

    train(13'h20, 13'h30, 1'b1, 1'b0);
    redirect(13'h20);
    chk("br_alloc", pc_predicted, 13'h30);
    train(13'h20, 13'h30, 1'b0, 1'b0);
    train(13'h20, 13'h30, 1'b0, 1'b0);
    redirect(13'h20);
    chk("br_nt_pred", pc_predicted, 13'h22);
    chk("br_nt_taken", {12'b0, pred_taken}, 13'd0);
    for (int i = 0; i < 4; i++) train(13'h20, 13'h30, 1'b1, 1'b0);
    train(13'h20, 13'h30, 1'b0, 1'b0);
    redirect(13'h20);
    chk("br_sat_pred", pc_predicted, 13'h30);

    idle();
    stall = 1'b1; d_fail = 1'b1; d_true_pc = 13'h100; e_fail = 1'b1; e_true_pc = 13'h200;
    step();
    chk("prio_e", pc1, 13'h200);
    idle();
    stall = 1'b1; d_fail = 1'b1; d_true_pc = 13'h100;
    step();
    chk("prio_d", pc1, 13'h100);
    idle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", pc1, 13'h100);
    end

    upd_valid = 1'b1; upd_pc = 13'h100; upd_target = 13'h555; upd_jal = 1'b1;
    chk("rbw_old", {12'b0, pred_taken}, 13'd0);
    step();
    upd_valid = 1'b0; upd_jal = 1'b0;
    chk("rbw_new_taken", {12'b0, pred_taken}, 13'd1);
    chk("rbw_new_pred", pc_predicted, 13'h555);

    idle();
    rst = 1'b1; e_fail = 1'b1; e_true_pc = 13'h300;
    step();
    chk("rst_over_e", pc1, 13'd0);
    redirect(13'h100);
    chk("rst_clr_a", {12'b0, pred_taken}, 13'd0);
    chk("rst_clr_b", pc_predicted, 13'h102);
    redirect(13'h20);
    chk("rst_clr_c", pc_predicted, 13'h22);

    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      d_fail     = ($urandom_range(0, 7) == 0);
      e_fail     = ($urandom_range(0, 9) == 0);
      d_true_pc  = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 63)) : 13'($urandom_range(0, 8191));
      e_true_pc  = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 63)) : 13'($urandom_range(0, 8191));
      upd_valid  = ($urandom_range(0, 1) == 0);
      upd_pc     = 13'($urandom_range(0, 63));
      upd_target = 13'($urandom_range(0, 8191));
      upd_taken  = ($urandom_range(0, 1) == 0);
      upd_jal    = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
